// File: rtl/hopfield_pkg.sv
// Shared definitions for the Hopfield recall sequencer: FSM state encoding,
// bipolar bit encoding and the accumulator sizing helper.
package hopfield_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Bipolar encoding of a neuron state bit
    localparam logic POS = 1'b1;
    localparam logic NEG = 1'b0;

    // Width that holds +/- n * 2^(ww-1) without wrap, plus sign
    function automatic int acc_width(input int ww, input int n);
        return ww + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/hopfield_mac_acc.sv
// Signed +/-w accumulator for one neuron's weighted sum. The running sum plus
// the current term is exposed combinationally so the final product of a row
// can be folded into the sign decision in the same cycle it arrives.
module hopfield_mac_acc
    import hopfield_pkg::*;
#(
    parameter int WW    = 8,
    parameter int ACC_W = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 add_en,
    input  logic                 sign_bit,
    input  logic signed [WW-1:0] w,
    output logic                 sum_pos,
    output logic                 sum_neg
);

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] w_ext_s;
    logic signed [ACC_W-1:0] term_s;
    logic signed [ACC_W-1:0] sum_s;

    // Sign-extend before negating so -(-2^(WW-1)) cannot wrap; form sum and decisions
    always_comb begin
        w_ext_s = {{(ACC_W-WW){w[WW-1]}}, w};
        term_s  = {ACC_W{1'b0}};
        if (add_en) begin
            if (sign_bit == POS) begin
                term_s = w_ext_s;
            end else begin
                term_s = -w_ext_s;
            end
        end else begin
            term_s = {ACC_W{1'b0}};
        end
        sum_s   = acc_r + term_s;
        sum_neg = sum_s[ACC_W-1];
        sum_pos = ~sum_s[ACC_W-1] & (sum_s != {ACC_W{1'b0}});
    end

    // Accumulator register: clear wins over accumulate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (add_en) begin
            acc_r <= sum_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/hopfield_recall_ctrl.sv
// Hopfield recall sequencer: streams weight rows from an external store with a
// one-cycle read latency, updates neurons in place one row at a time and
// repeats sweeps until a sweep changes nothing or the sweep limit is reached.
module hopfield_recall_ctrl
    import hopfield_pkg::*;
#(
    parameter int N        = 16,
    parameter int WW       = 8,
    parameter int MAX_ITER = 8,
    localparam int AW      = $clog2(N),
    localparam int ACC_W   = acc_width(WW, N),
    localparam int IW      = $clog2(MAX_ITER + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N-1:0]         pattern_in,
    output logic                 wt_rd,
    output logic [2*AW-1:0]      wt_addr,
    input  logic signed [WW-1:0] wt_data,
    output logic                 busy,
    output logic                 done,
    output logic                 converged,
    output logic [IW-1:0]        iter_count,
    output logic [N-1:0]         pattern_out
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);
    localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);
    localparam logic [IW-1:0] ONE_ITER = IW'(1);

    state_e          state_r, state_s;
    logic [AW-1:0]   row_r, row_s;
    logic [AW-1:0]   col_r, col_s;
    logic [AW-1:0]   col_d_r;
    logic            rd_d_r;
    logic            wt_rd_r;
    logic            busy_r;
    logic            done_r;
    logic            conv_r, conv_s;
    logic            changed_r, changed_s;
    logic [IW-1:0]   iter_r, iter_s;
    logic [IW-1:0]   iter_inc_s;
    logic [N-1:0]    pattern_r, pattern_s;

    logic            abort_s;
    logic            wt_rd_s, busy_s, done_s;
    logic            mac_clr_s, mac_add_s;
    logic            sum_pos_s, sum_neg_s;
    logic            new_bit_s;

    assign abort_s    = abort & (state_r != ST_IDLE);
    assign iter_inc_s = iter_r + ONE_ITER;
    assign new_bit_s  = sum_pos_s ? POS : (sum_neg_s ? NEG : pattern_r[row_r]);

    hopfield_mac_acc #(
        .WW    (WW),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr_s),
        .add_en   (mac_add_s),
        .sign_bit (pattern_r[col_d_r]),
        .w        (wt_data),
        .sum_pos  (sum_pos_s),
        .sum_neg  (sum_neg_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; abort overrides every active state
    always_comb begin
        state_s = state_r;
        if (abort_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) state_s = ST_ACCUM;
                    else       state_s = ST_IDLE;
                end
                ST_ACCUM: begin
                    if (col_r == LAST_IDX) state_s = ST_UPDATE;
                    else                   state_s = ST_ACCUM;
                end
                ST_UPDATE: begin
                    if (row_r == LAST_IDX) state_s = ST_CHECK;
                    else                   state_s = ST_ACCUM;
                end
                ST_CHECK: begin
                    if (!changed_r || (iter_inc_s == ITER_MAX)) state_s = ST_DONE;
                    else                                        state_s = ST_ACCUM;
                end
                ST_DONE:  state_s = ST_IDLE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // FSM output decode: next-cycle strobes and accumulator controls
    always_comb begin
        wt_rd_s   = (state_s == ST_ACCUM);
        busy_s    = (state_s != ST_IDLE);
        done_s    = (state_s == ST_DONE);
        mac_add_s = rd_d_r & ((state_r == ST_ACCUM) | (state_r == ST_UPDATE));
        mac_clr_s = abort_s | (state_r == ST_UPDATE) | ((state_r == ST_IDLE) & start);
    end

    // Datapath next values: counters, working pattern, change and convergence flags
    always_comb begin
        row_s     = row_r;
        col_s     = col_r;
        changed_s = changed_r;
        iter_s    = iter_r;
        conv_s    = conv_r;
        pattern_s = pattern_r;
        if (abort_s) begin
            conv_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        pattern_s = pattern_in;
                        row_s     = {AW{1'b0}};
                        col_s     = {AW{1'b0}};
                        changed_s = 1'b0;
                        iter_s    = {IW{1'b0}};
                        conv_s    = 1'b0;
                    end else begin
                        pattern_s = pattern_r;
                    end
                end
                ST_ACCUM: begin
                    col_s = col_r + ONE_IDX;
                end
                ST_UPDATE: begin
                    pattern_s[row_r] = new_bit_s;
                    if (new_bit_s != pattern_r[row_r]) changed_s = 1'b1;
                    else                               changed_s = changed_r;
                    row_s = row_r + ONE_IDX;
                    col_s = {AW{1'b0}};
                end
                ST_CHECK: begin
                    iter_s = iter_inc_s;
                    if (!changed_r) begin
                        conv_s = 1'b1;
                    end else if (iter_inc_s == ITER_MAX) begin
                        conv_s = 1'b0;
                    end else begin
                        changed_s = 1'b0;
                    end
                end
                ST_DONE: begin
                    conv_s = conv_r;
                end
                default: begin
                    conv_s = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers; a read in flight at abort is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_r     <= {AW{1'b0}};
            col_r     <= {AW{1'b0}};
            col_d_r   <= {AW{1'b0}};
            rd_d_r    <= 1'b0;
            wt_rd_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            conv_r    <= 1'b0;
            changed_r <= 1'b0;
            iter_r    <= {IW{1'b0}};
            pattern_r <= {N{1'b0}};
        end else begin
            row_r     <= row_s;
            col_r     <= col_s;
            col_d_r   <= col_r;
            rd_d_r    <= wt_rd_r & ~abort_s;
            wt_rd_r   <= wt_rd_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            conv_r    <= conv_s;
            changed_r <= changed_s;
            iter_r    <= iter_s;
            pattern_r <= pattern_s;
        end
    end

    assign wt_rd       = wt_rd_r;
    assign wt_addr     = {row_r, col_r};
    assign busy        = busy_r;
    assign done        = done_r;
    assign converged   = conv_r;
    assign iter_count  = iter_r;
    assign pattern_out = pattern_r;

endmodule

// File: tb/tb_hopfield_recall_ctrl.sv
// Scoreboard bench for hopfield_recall_ctrl (N=16, WW=8, MAX_ITER=4) with a
// one-cycle-latency weight store model holding several directed weight sets.
module tb_hopfield_recall_ctrl;

    localparam int SC = 273;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [15:0]        pattern_in;
    logic               wt_rd;
    logic [7:0]         wt_addr;
    logic signed [7:0]  wt_data;
    logic               busy;
    logic               done;
    logic               converged;
    logic [2:0]         iter_count;
    logic [15:0]        pattern_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e0    = 0;
    int mode  = 0;

    typedef struct {
        logic [15:0] pat;
        logic        conv;
        logic [2:0]  iter;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    hopfield_recall_ctrl #(
        .N        (16),
        .WW       (8),
        .MAX_ITER (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pattern_in  (pattern_in),
        .wt_rd       (wt_rd),
        .wt_addr     (wt_addr),
        .wt_data     (wt_data),
        .busy        (busy),
        .done        (done),
        .converged   (converged),
        .iter_count  (iter_count),
        .pattern_out (pattern_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Weight sets: 0 all zero, 1 Hebb of A5A5, 2 diag -1, 3 all 0x80
    function automatic logic signed [7:0] wfun(input int m, input logic [3:0] i, input logic [3:0] j);
        logic [15:0] p;
        p = 16'hA5A5;
        case (m)
            0: return 8'sd0;
            1: begin
                if (i == j)         return 8'sd0;
                else if (p[i] == p[j]) return 8'sd1;
                else                return -8'sd1;
            end
            2: return (i == j) ? -8'sd1 : 8'sd0;
            default: return 8'sh80;
        endcase
    endfunction

    // Weight store: data valid one cycle after the read strobe, junk otherwise
    always @(posedge clk) begin
        if (wt_rd) wt_data <= wfun(mode, wt_addr[7:4], wt_addr[3:0]);
        else       wt_data <= 8'sh5A;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic kick(input logic [15:0] p, input int m);
        @(negedge clk);
        mode       = m;
        pattern_in = p;
        start      = 1'b1;
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("wt_rd_after_start", 32'(wt_rd), 32'd1);
        chk("wt_addr_first", 32'(wt_addr), 32'd0);
    endtask

    task automatic push_exp(input logic [15:0] p, input logic c, input logic [2:0] it, input int k);
        exp_t e;
        e.pat  = p;
        e.conv = c;
        e.iter = it;
        e.cyc  = e0 + k * SC;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        #1;
        chk("busy_falls_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wt_rd"}, 32'(wt_rd), 32'd0);
        chk({tag, "_wt_addr"}, 32'(wt_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_converged"}, 32'(converged), 32'd0);
        chk({tag, "_iter_count"}, 32'(iter_count), 32'd0);
        chk({tag, "_pattern_out"}, 32'(pattern_out), 32'd0);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pattern_out", 32'(pattern_out), 32'(e.pat));
                    chk("converged", 32'(converged), 32'(e.conv));
                    chk("iter_count", 32'(iter_count), 32'(e.iter));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_in_done", 32'(busy), 32'd1);
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        pattern_in = 16'h0000;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Zero weights: all sums zero, one sweep, converged
        kick(16'h3C5A, 0);
        push_exp(16'h3C5A, 1'b1, 3'd1, 1);
        drain(400);
        chk("converged_held_idle", 32'(converged), 32'd1);

        // Hebb recall of A5A5 from two flipped bits
        kick(16'hA5A6, 1);
        push_exp(16'hA5A5, 1'b1, 3'd2, 2);
        drain(700);

        // Diagonal -1: every bit flips every sweep, stops at the limit;
        // a second start while busy must be ignored
        kick(16'h00FF, 2);
        push_exp(16'h00FF, 1'b0, 3'd4, 4);
        repeat (30) @(negedge clk);
        pattern_in = 16'hFFFF;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        drain(1300);
        repeat (20) @(negedge clk);

        // Most negative weight everywhere: row 0 sum +2048 without wrap
        kick(16'h0000, 3);
        push_exp(16'h00FF, 1'b1, 3'd2, 2);
        repeat (17) @(posedge clk);
        #1;
        chk("row0_after_first_update", 32'(pattern_out[1:0]), 32'd1);
        drain(700);

        // Async reset mid-sweep
        kick(16'h3C5A, 0);
        repeat (99) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        chk("no_done_after_rst", 32'(busy), 32'd0);

        // Abort mid-sweep, then a fresh run completes normally
        kick(16'h3C5A, 0);
        repeat (49) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_wt_rd", 32'(wt_rd), 32'd0);
        chk("abort_converged", 32'(converged), 32'd0);
        chk("abort_pattern_hold", 32'(pattern_out), 32'h3C5A);
        repeat (300) @(negedge clk);
        kick(16'hA5A6, 1);
        push_exp(16'hA5A5, 1'b1, 3'd2, 2);
        drain(700);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hopfield_recall_ctrl.md
# hopfield_recall_ctrl

Sequencer for Hopfield pattern recall. It accepts a start request with a bipolar input pattern and fetches Hebbian weights row by row from an external weight store. It accumulates the weighted sum for each neuron, updates neurons one at a time in place (asynchronous update), and repeats full sweeps until a sweep changes no bit or an iteration limit is reached. It sits between the system controller and the weight memory, replacing ad-hoc counter/compare sequencing with a single start/done FSM.

## Interface
- N, 16, neuron count (power of 2, ≥4)
- WW, 8, signed weight width
- MAX_ITER, 8, sweep limit (≥1)
- AW (localparam), $clog2(N), index width
- ACC_W (localparam), WW+AW+1, signed accumulator width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE, no done
- pattern_in  in  N  initial pattern; bit 1 = +1, bit 0 = −1
- wt_rd  out  1  weight read strobe
- wt_addr  out  2*AW  {row, col}
- wt_data  in  WW  signed weight, valid exactly 1 cycle after wt_rd
- busy  out  1  high from start acceptance until DONE exits
- done  out  1  one-cycle pulse in DONE
- converged  out  1  valid while done high; held until next start
- iter_count  out  $clog2(MAX_ITER+1)  sweeps executed
- pattern_out  out  N  working pattern; final result when done high

## Operation
- States: IDLE, ACCUM, UPDATE, CHECK, DONE.
- IDLE: start=1 captures pattern_in into the working pattern. It clears row, col, acc, changed and iter_count, then enters ACCUM. start while busy is ignored.
- ACCUM: N cycles, col 0..N−1. wt_rd=1 and wt_addr={row,col}. acc += s_col ? w : −w, applied the cycle the data returns, using the current working bits (bits already updated this sweep included). Diagonal is not skipped.
- UPDATE: 1 cycle. The last product is folded in combinationally to form the final sum.
  - sum>0 → bit 1; sum<0 → bit 0; sum==0 → bit unchanged.
  - Writes pattern[row]. A bit flip sets changed. Clears acc.
  - row<N−1 → row+1, ACCUM; else → CHECK.
- CHECK: iter_count+1.
  - changed==0 → converged=1, DONE.
  - Else if iter_count+1==MAX_ITER → converged=0, DONE.
  - Else clear changed, row=0, ACCUM.
- DONE: done=1 for one cycle, busy stays 1 → IDLE.
- abort in any non-IDLE state: IDLE next edge. busy=0, done not pulsed, pattern_out holds partial result, converged=0.
- Arithmetic: two's complement. ACC_W covers ±N·2^(WW−1), so there is no wrap (−(−2^(WW−1)) is sign-extended first).

## Timing
- Reset: state IDLE. wt_rd, wt_addr, busy, done, converged, iter_count, pattern_out, acc all 0.
- Row cost N+1 cycles; sweep cost S_C = N(N+1)+1 (273 for N=16).
- Start accepted at edge E0 → busy=1 after E0. wt_rd first high in cycle after E0.
- DONE entered at edge E0 + k·S_C for k sweeps. busy falls at the following edge.
- wt_rd is never high in UPDATE/CHECK/DONE/IDLE. A returning wt_data is consumed exactly 1 cycle later, including across the ACCUM→UPDATE boundary.
- Async reset mid-sweep: immediate IDLE and all outputs 0. Any in-flight read is discarded.

## Structure
- hopfield_pkg: state enum, bipolar encoding constants (POS=1'b1, NEG=1'b0), acc_width function.
- Sub-module hopfield_mac_acc: signed ±w accumulate, clear, sign/zero decision. The FSM, counters and pattern register stay in hopfield_recall_ctrl.
- Weight store model stays in the bench (1-cycle read latency).

## Test plan
- All weights 0, pattern_in=16'h3C5A → every sum 0, bits held. converged=1, iter_count=1, pattern_out=16'h3C5A, done at E0+273.
- Hebb weights for P=16'hA5A5 (w_ij=p_i·p_j, w_ii=0), pattern_in=16'hA5A6 → pattern_out=16'hA5A5, converged=1, iter_count=2, done at E0+546.
- MAX_ITER=4, w_ii=−1, others 0, pattern_in=16'h00FF → every bit flips each sweep. converged=0, iter_count=4, pattern_out=16'h00FF.
- All w=8'h80, pattern_in=16'h0000 → row0 sum=+2048 with no wrap, pattern[0]=1 after first UPDATE.
- Async rst low at cycle 100 → all outputs 0 within the cycle. start while busy ignored (iter_count unchanged, no second done).
- abort at cycle 50 → IDLE next edge, busy=0, no done pulse. A new start then completes normally.
